// File: rtl/prog_loader_pkg.sv
// Shared constants and FSM state encoding for the UART program loader.
package prog_loader_pkg;

  localparam logic [7:0] SOP    = 8'h23;
  localparam logic [7:0] EOP    = 8'h0d;
  localparam logic [7:0] CMD_WR = 8'h07;
  localparam logic [7:0] CMD_RD = 8'h08;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StLen,
    StData,
    StChk,
    StEop,
    StResp
  } state_e;

endpackage

// File: rtl/prog_loader_resp.sv
// Response sequencer: holds up to three bytes and streams them out on valid/ready.
module prog_loader_resp (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [23:0] load_bytes,
  input  logic [1:0]  load_cnt,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy
);

  logic [23:0] q_q, q_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next-state: load a fresh response, or pop the head byte on each transfer.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (load) begin
      q_d   = load_bytes;
      cnt_d = load_cnt;
    end else if (cnt_q != 2'd0 && tx_ready) begin
      q_d   = {8'h00, q_q[23:8]};
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Queue registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  // Head byte only changes on a transfer, so data stays stable while stalled.
  assign tx_valid = (cnt_q != 2'd0);
  assign tx_data  = q_q[7:0];
  assign busy     = tx_valid;

endmodule

// File: rtl/prog_loader.sv
// UART packet parser that writes program words into RAM and answers ACK/NAK.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        progmem_wen,
  output logic [31:0] progmem_waddr,
  output logic [31:0] progmem_wdata,
  output logic        busy
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [31:0]       addr_q, addr_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        chk_q, chk_d;
  logic              chk_ok_q, chk_ok_d;
  logic              err_q, err_d;
  logic [15:0]       words_q, words_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              wen_q, wen_d;
  logic [31:0]       waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              timeout;
  logic              resp_ok;
  logic              resp_load;
  logic [23:0]       resp_bytes;
  logic [1:0]        resp_cnt;
  logic              resp_busy;

  // Packet parser: one state step per accepted byte, plus the inter-byte timeout.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    word_d     = word_q;
    chk_d      = chk_q;
    chk_ok_d   = chk_ok_q;
    err_d      = err_q;
    words_d    = words_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wen_d      = 1'b0;
    timeout    = 1'b0;
    resp_ok    = 1'b0;
    resp_load  = 1'b0;
    resp_bytes = '0;
    resp_cnt   = '0;

    if (state_q == StIdle || state_q == StResp || rx_valid) begin
      timer_d = '0;
    end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
      timer_d = '0;
      timeout = 1'b1;
    end else begin
      timer_d = timer_q + TimerW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (rx_valid && rx_data == SOP) begin
          state_d = StCmd;
          chk_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
        end
      end
      StCmd: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          chk_d   = chk_q + rx_data;
          err_d   = err_q | (rx_data != CMD_WR && rx_data != CMD_RD);
          idx_d   = '0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (rx_valid) begin
          chk_d = chk_q + rx_data;
          unique case (idx_q)
            2'd0:    addr_d[7:0]   = rx_data;
            2'd1:    addr_d[15:8]  = rx_data;
            2'd2:    addr_d[23:16] = rx_data;
            default: addr_d[31:24] = rx_data;
          endcase
          // Misalignment is visible from the first address byte.
          if (idx_q == 2'd0 && rx_data[1:0] != 2'b00) err_d = 1'b1;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StLen;
        end
      end
      StLen: begin
        if (rx_valid) begin
          chk_d = chk_q + rx_data;
          if (idx_q == 2'd0) begin
            len_d[7:0] = rx_data;
            if (cmd_q == CMD_WR && rx_data[1:0] != 2'b00) err_d = 1'b1;
            idx_d = 2'd1;
          end else begin
            len_d[15:8] = rx_data;
            if (cmd_q == CMD_RD && {rx_data, len_q[7:0]} != 16'd0) err_d = 1'b1;
            idx_d   = '0;
            state_d = ({rx_data, len_q[7:0]} == 16'd0) ? StChk : StData;
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          chk_d  = chk_q + rx_data;
          word_d = {rx_data, word_q[31:8]};
          len_d  = len_q - 16'd1;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3 && !err_q) begin
            wen_d   = 1'b1;
            waddr_d = addr_q;
            wdata_d = {rx_data, word_q[31:8]};
            addr_d  = addr_q + 32'd4;
            if (words_q != 16'hffff) words_d = words_q + 16'd1;
          end
          if (len_q == 16'd1) state_d = StChk;
        end
      end
      StChk: begin
        if (rx_valid) begin
          chk_ok_d = (rx_data == chk_q);
          state_d  = StEop;
        end
      end
      StEop: begin
        if (rx_valid) begin
          resp_ok   = !err_q && chk_ok_q && (rx_data == EOP);
          resp_load = 1'b1;
          if (cmd_q == CMD_RD && resp_ok) begin
            resp_bytes = {words_q[15:8], words_q[7:0], ACK};
            resp_cnt   = 2'd3;
          end else begin
            resp_bytes = {16'h0000, resp_ok ? ACK : NAK};
            resp_cnt   = 2'd1;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        // Incoming bytes are dropped until the response has fully drained.
        if (!resp_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (timeout) state_d = StIdle;
  end

  // Parser state and write-port registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cmd_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      chk_q    <= '0;
      chk_ok_q <= 1'b0;
      err_q    <= 1'b0;
      words_q  <= '0;
      timer_q  <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      chk_q    <= chk_d;
      chk_ok_q <= chk_ok_d;
      err_q    <= err_d;
      words_q  <= words_d;
      timer_q  <= timer_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  prog_loader_resp u_resp (
    .clk        (clk),
    .reset      (reset),
    .load       (resp_load),
    .load_bytes (resp_bytes),
    .load_cnt   (resp_cnt),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .busy       (resp_busy)
  );

  assign progmem_wen   = wen_q;
  assign progmem_waddr = waddr_q;
  assign progmem_wdata = wdata_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader against a packet-level reference model.
module tb_prog_loader;

  localparam int unsigned Tmo = 40;
  localparam logic [7:0] Sop = 8'h23, Eop = 8'h0d, Wr = 8'h07, Rd = 8'h08;
  localparam logic [7:0] Ack = 8'h06, Nak = 8'h15;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        progmem_wen;
  logic [31:0] progmem_waddr;
  logic [31:0] progmem_wdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  bit hold_ready = 1'b0;
  int model_words = 0;

  logic [7:0]  pay [64];
  logic [31:0] cap_addr[$], cap_data[$], exp_addr[$], exp_data[$];
  logic [7:0]  cap_tx[$], exp_tx[$];

  prog_loader #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .progmem_wen   (progmem_wen),
    .progmem_waddr (progmem_waddr),
    .progmem_wdata (progmem_wdata),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Random backpressure on the TX side unless a test is holding it off.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Capture writes and completed TX transfers mid-cycle.
  always @(negedge clk) begin
    if (progmem_wen) begin
      cap_addr.push_back(progmem_waddr);
      cap_data.push_back(progmem_wdata);
    end
    if (tx_valid && tx_ready && !reset) cap_tx.push_back(tx_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
    step(gap);
  endtask

  task automatic clear_caps();
    cap_addr.delete(); cap_data.delete(); cap_tx.delete();
    exp_addr.delete(); exp_data.delete(); exp_tx.delete();
  endtask

  task automatic compare_caps(input string tag);
    check_eq({tag, "_nwr"}, 32'(cap_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
      check_eq({tag, "_waddr"}, cap_addr[i], exp_addr[i]);
      check_eq({tag, "_wdata"}, cap_data[i], exp_data[i]);
    end
    check_eq({tag, "_ntx"}, 32'(cap_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < cap_tx.size() && i < exp_tx.size(); i++)
      check_eq({tag, "_tx"}, 32'(cap_tx[i]), 32'(exp_tx[i]));
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 3000) begin step(1); t++; end
    if (busy) check_eq({tag, "_idle_bound"}, 32'd1, 32'd0);
    step(3);
  endtask

  // Builds a packet, predicts writes and response from the packet rules, sends and checks.
  task automatic run_packet(input string tag, input logic [7:0] cmd, input logic [31:0] addr,
                            input int len, input int delta, input logic [7:0] eop,
                            input bit hold);
    logic [7:0] pkt[$];
    logic [7:0] sum, b;
    bit err, ok;
    int t;
    clear_caps();
    pkt.push_back(Sop);
    pkt.push_back(cmd);
    for (int i = 0; i < 4; i++) pkt.push_back(8'(addr >> (8 * i)));
    pkt.push_back(8'(len));
    pkt.push_back(8'(len >> 8));
    for (int i = 0; i < len; i++) pkt.push_back(pay[i]);
    sum = 8'h00;
    for (int i = 1; i < pkt.size(); i++) sum = sum + pkt[i];
    pkt.push_back(sum + 8'(delta));
    pkt.push_back(eop);

    err = !(cmd == Wr || cmd == Rd) || addr[1:0] != 2'b00 ||
          (cmd == Wr && len % 4 != 0) || (cmd == Rd && len != 0);
    if (cmd == Wr && !err) begin
      for (int k = 0; k < len / 4; k++) begin
        exp_addr.push_back(addr + 32'(4 * k));
        exp_data.push_back({pay[4*k+3], pay[4*k+2], pay[4*k+1], pay[4*k]});
        if (model_words < 65535) model_words++;
      end
    end
    ok = !err && delta == 0 && eop == Eop;
    if (cmd == Rd && ok) begin
      exp_tx.push_back(Ack);
      exp_tx.push_back(8'(model_words));
      exp_tx.push_back(8'(model_words >> 8));
    end else begin
      exp_tx.push_back(ok ? Ack : Nak);
    end

    if (hold) hold_ready = 1'b1;
    // Line noise before the start byte must be ignored.
    for (int i = 0; i < $urandom_range(0, 2); i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == Sop) b = 8'h00;
      send_byte(b, $urandom_range(0, 2));
    end
    foreach (pkt[i]) send_byte(pkt[i], $urandom_range(0, 3));

    if (hold) begin
      t = 0;
      while (!tx_valid && t < 20) begin step(1); t++; end
      for (int c = 0; c < 10; c++) begin
        check_eq({tag, "_hold_valid"}, 32'(tx_valid), 32'd1);
        check_eq({tag, "_hold_data"}, 32'(tx_data), 32'(exp_tx[0]));
        step(1);
      end
      hold_ready = 1'b0;
    end
    wait_idle(tag);
    compare_caps(tag);
  endtask

  initial begin
    logic [7:0]  cmd;
    logic [31:0] addr;
    int          len, r;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    step(3);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_wen", 32'(progmem_wen), 32'd0);
    check_eq("rst_waddr", progmem_waddr, 32'd0);
    check_eq("rst_wdata", progmem_wdata, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step(2);

    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    run_packet("wr_basic", Wr, 32'h0000_0100, 8, 0, Eop, 1'b0);
    run_packet("rd_hold", Rd, 32'h0, 0, 0, Eop, 1'b1);
    run_packet("wr_badchk", Wr, 32'h0000_0100, 8, 1, Eop, 1'b0);
    run_packet("wr_badaddr", Wr, 32'h0000_0102, 8, 0, Eop, 1'b0);
    run_packet("wr_badlen", Wr, 32'h0000_0100, 6, 0, Eop, 1'b0);
    run_packet("wr_len0", Wr, 32'h0000_0040, 0, 0, Eop, 1'b0);
    run_packet("rd_len", Rd, 32'h0, 3, 0, Eop, 1'b0);

    // Timeout after 6 of 8 data bytes: the first word lands, the partial one is dropped.
    clear_caps();
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom_range(0, 255));
    send_byte(Sop, 1); send_byte(Wr, 1);
    send_byte(8'h00, 1); send_byte(8'h02, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    send_byte(8'h08, 1); send_byte(8'h00, 1);
    for (int i = 0; i < 6; i++) send_byte(pay[i], (i == 5) ? 0 : 1);
    exp_addr.push_back(32'h0000_0200);
    exp_data.push_back({pay[3], pay[2], pay[1], pay[0]});
    model_words++;
    step(Tmo - 2);
    check_eq("tmo_busy_before", 32'(busy), 32'd1);
    step(3);
    check_eq("tmo_busy_after", 32'(busy), 32'd0);
    step(5);
    compare_caps("tmo");

    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom_range(0, 255));
    run_packet("wr_wrap", Wr, 32'hFFFF_FFFC, 8, 0, Eop, 1'b0);

    // Reset after the third byte, colliding with the fourth byte's strobe.
    clear_caps();
    send_byte(Sop, 1); send_byte(Wr, 1); send_byte(8'h00, 1);
    rx_data = 8'h00; rx_valid = 1'b1; reset = 1'b1;
    step(1);
    rx_valid = 1'b0; reset = 1'b0;
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    model_words = 0;
    send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h08, 1); send_byte(8'h00, 1);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 1);
    send_byte(8'h33, 1); send_byte(Eop, 1);
    step(10);
    check_eq("rst_mid_busy_end", 32'(busy), 32'd0);
    compare_caps("rst_mid");
    run_packet("rd_after_rst", Rd, 32'h0, 0, 0, Eop, 1'b0);

    for (int n = 0; n < 14; n++) begin
      r = $urandom_range(0, 9);
      cmd = (r < 6) ? Wr : (r < 8) ? Rd : 8'($urandom_range(0, 255));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      if (cmd == Rd) len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      else len = 4 * $urandom_range(0, 4) + (($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom_range(0, 255));
      run_packet("rand", cmd, addr, len, ($urandom_range(0, 4) == 0) ? 1 : 0,
                 ($urandom_range(0, 5) == 0) ? 8'h0a : Eop, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
